// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: source bit positions,
// service vectors, FSM state encoding and the priority-select helpers.
package interrupt_controller_pkg;

    localparam int NUM_INT = 5;

    // Bit positions of each request source inside IF/IE
    localparam int IDX_VBLANK = 0;
    localparam int IDX_LCDC   = 1;
    localparam int IDX_TIMER  = 2;
    localparam int IDX_SERIAL = 3;
    localparam int IDX_JOYPAD = 4;

    // Service addresses; VEC_NONE is used when a dispatch is cancelled
    localparam logic [15:0] VEC_VBLANK = 16'h0040;
    localparam logic [15:0] VEC_LCDC   = 16'h0048;
    localparam logic [15:0] VEC_TIMER  = 16'h0050;
    localparam logic [15:0] VEC_SERIAL = 16'h0058;
    localparam logic [15:0] VEC_JOYPAD = 16'h0060;
    localparam logic [15:0] VEC_NONE   = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQUEST  = 2'd1,
        ST_DISPATCH = 2'd2
    } state_t;

    // Service address of the lowest-numbered set bit; VEC_NONE if none set
    function automatic logic [15:0] vector_of(input logic [NUM_INT-1:0] pend);
        logic [15:0] v;
        v = VEC_NONE;
        if (pend[IDX_VBLANK])      v = VEC_VBLANK;
        else if (pend[IDX_LCDC])   v = VEC_LCDC;
        else if (pend[IDX_TIMER])  v = VEC_TIMER;
        else if (pend[IDX_SERIAL]) v = VEC_SERIAL;
        else if (pend[IDX_JOYPAD]) v = VEC_JOYPAD;
        return v;
    endfunction

    // One-hot mask of the lowest-numbered set bit (zero if none set)
    function automatic logic [NUM_INT-1:0] lowest_bit(input logic [NUM_INT-1:0] pend);
        return pend & (~pend + {{(NUM_INT-1){1'b0}}, 1'b1});
    endfunction

endpackage

// File: rtl/tristate.sv
// Generic tristate bus driver: drives io_bus with i_data while i_en is high,
// otherwise releases the bus to high impedance.
module tristate #(
    parameter int WIDTH = 8
) (
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_data,
    inout  wire  [WIDTH-1:0] io_bus
);

    assign io_bus = i_en ? i_data : {WIDTH{1'bz}};

endmodule

// File: rtl/interrupt_controller.sv
// Five-source interrupt controller with IF/IE registers on the CPU data bus,
// an IME/EI-delay unit and a request/acknowledge dispatch FSM.
module interrupt_controller
    import interrupt_controller_pkg::*;
(
    input  logic        cpu_clock,
    input  logic        reset,
    inout  wire  [7:0]  data_ext,
    input  logic        addr_in_IF,
    input  logic        addr_in_IE,
    input  logic        mem_we,
    input  logic        mem_re,
    input  logic        vblank_int,
    input  logic        lcdc_int,
    input  logic        timer_int,
    input  logic        link_cable_interrupt,
    input  logic        joypad_int,
    input  logic        ei,
    input  logic        di,
    input  logic        reti,
    input  logic        instr_done,
    input  logic        int_ack,
    output logic        int_req,
    output logic [15:0] int_vector,
    output logic        int_vector_valid,
    output logic        halt_wake
);

    logic [NUM_INT-1:0] r_if;
    logic [7:0]         r_ie;
    logic               r_ime;
    logic               r_arm;
    state_t             r_state;
    logic               r_int_req;
    logic [15:0]        r_vector;
    logic               r_vector_valid;
    logic               r_halt_wake;

    logic [NUM_INT-1:0] w_src;
    logic               w_wr_if;
    logic               w_wr_ie;
    logic [NUM_INT-1:0] w_if_base;
    logic [7:0]         w_ie_base;
    logic [NUM_INT-1:0] w_pending;
    logic [NUM_INT-1:0] w_pending_ack;
    logic [NUM_INT-1:0] w_ack_clear;
    logic [NUM_INT-1:0] w_if_next;
    logic               w_ime_next;
    logic               w_arm_next;
    logic               w_accept;
    state_t             w_state_next;
    logic               w_rd_if;
    logic               w_rd_ie;

    // Map the individual request pulses onto their IF bit positions
    always_comb begin
        w_src             = '0;
        w_src[IDX_VBLANK] = vblank_int;
        w_src[IDX_LCDC]   = lcdc_int;
        w_src[IDX_TIMER]  = timer_int;
        w_src[IDX_SERIAL] = link_cable_interrupt;
        w_src[IDX_JOYPAD] = joypad_int;
    end

    assign w_wr_if   = mem_we & addr_in_IF;
    assign w_wr_ie   = mem_we & addr_in_IE;
    assign w_if_base = w_wr_if ? data_ext[NUM_INT-1:0] : r_if;
    assign w_ie_base = w_wr_ie ? data_ext : r_ie;

    // Flagged-and-enabled sources as seen by the request path
    assign w_pending = r_if & r_ie[NUM_INT-1:0];

    // At acknowledge time a same-cycle IF/IE write already counts, so a CPU
    // write can cancel (or retarget) a dispatch in the very cycle it is acked.
    // A source pulse in that cycle is not yet flagged and so is not eligible.
    assign w_pending_ack = w_if_base & w_ie_base[NUM_INT-1:0];
    assign w_ack_clear   = w_accept ? lowest_bit(w_pending_ack) : '0;

    // Per-bit IF update: write-or-hold, OR new pulses, then drop the serviced
    // bit unless its own source re-fires in the same cycle
    generate
        for (genvar gi = 0; gi < NUM_INT; gi++) begin : g_if_bit
            assign w_if_next[gi] = (w_if_base[gi] | w_src[gi]) &
                                   ~(w_ack_clear[gi] & ~w_src[gi]);
        end
    endgenerate

    // Dispatch FSM next-state: request while enabled work exists, dispatch on ack
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_ime && (|w_pending)) w_state_next = ST_REQUEST;
            end
            ST_REQUEST: begin
                if (!(r_ime && (|w_pending))) begin
                    w_state_next = ST_IDLE;
                end else if (int_ack) begin
                    w_state_next = ST_DISPATCH;
                    w_accept     = 1'b1;
                end
            end
            ST_DISPATCH: w_state_next = ST_IDLE;
            default:     w_state_next = ST_IDLE;
        endcase
    end

    // IME next-state: di dominates, ei takes effect at the following boundary,
    // and an accepted dispatch always closes the master enable
    always_comb begin
        w_ime_next = r_ime;
        w_arm_next = r_arm;
        if (di) begin
            w_ime_next = 1'b0;
            w_arm_next = 1'b0;
        end else begin
            if (reti) w_ime_next = 1'b1;
            if (r_arm && instr_done) begin
                w_ime_next = 1'b1;
                w_arm_next = 1'b0;
            end
            if (ei) w_arm_next = 1'b1;
        end
        if (w_accept) w_ime_next = 1'b0;
    end

    // Architectural state: IF, IE, IME, EI arm and FSM state
    always_ff @(posedge cpu_clock or posedge reset) begin
        if (reset) begin
            r_if    <= '0;
            r_ie    <= '0;
            r_ime   <= 1'b0;
            r_arm   <= 1'b0;
            r_state <= ST_IDLE;
        end else begin
            r_if    <= w_if_next;
            r_ie    <= w_ie_base;
            r_ime   <= w_ime_next;
            r_arm   <= w_arm_next;
            r_state <= w_state_next;
        end
    end

    // Registered CPU-facing outputs; the vector is only updated on dispatch
    always_ff @(posedge cpu_clock or posedge reset) begin
        if (reset) begin
            r_int_req      <= 1'b0;
            r_vector       <= VEC_NONE;
            r_vector_valid <= 1'b0;
            r_halt_wake    <= 1'b0;
        end else begin
            r_int_req      <= (w_state_next == ST_REQUEST);
            r_vector_valid <= (w_state_next == ST_DISPATCH);
            r_halt_wake    <= |w_pending;
            if (w_accept) r_vector <= vector_of(w_pending_ack);
        end
    end

    assign int_req          = r_int_req;
    assign int_vector       = r_vector;
    assign int_vector_valid = r_vector_valid;
    assign halt_wake        = r_halt_wake;

    // Register readback onto the shared bus; unused IF bits read as ones
    assign w_rd_if = mem_re & addr_in_IF;
    assign w_rd_ie = mem_re & addr_in_IE;

    tristate #(.WIDTH(8)) u_tri_if (
        .i_en   (w_rd_if),
        .i_data ({3'b111, r_if}),
        .io_bus (data_ext)
    );

    tristate #(.WIDTH(8)) u_tri_ie (
        .i_en   (w_rd_ie),
        .i_data (r_ie),
        .io_bus (data_ext)
    );

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: a cycle-level reference model
// is compared every cycle, plus directed scenarios with literal expectations.
module tb_interrupt_controller;

    logic        cpu_clock = 1'b0;
    logic        reset;
    wire  [7:0]  data_ext;
    logic [7:0]  drv;
    logic        drv_en;
    logic        addr_in_IF, addr_in_IE, mem_we, mem_re;
    logic        vblank_int, lcdc_int, timer_int, link_cable_interrupt, joypad_int;
    logic        ei, di, reti, instr_done, int_ack;
    logic        int_req;
    logic [15:0] int_vector;
    logic        int_vector_valid;
    logic        halt_wake;

    int n_checks = 0;
    int n_errors = 0;

    assign data_ext = drv_en ? drv : 8'bz;

    always #5 cpu_clock = ~cpu_clock;

    interrupt_controller dut (
        .cpu_clock            (cpu_clock),
        .reset                (reset),
        .data_ext             (data_ext),
        .addr_in_IF           (addr_in_IF),
        .addr_in_IE           (addr_in_IE),
        .mem_we               (mem_we),
        .mem_re               (mem_re),
        .vblank_int           (vblank_int),
        .lcdc_int             (lcdc_int),
        .timer_int            (timer_int),
        .link_cable_interrupt (link_cable_interrupt),
        .joypad_int           (joypad_int),
        .ei                   (ei),
        .di                   (di),
        .reti                 (reti),
        .instr_done           (instr_done),
        .int_ack              (int_ack),
        .int_req              (int_req),
        .int_vector           (int_vector),
        .int_vector_valid     (int_vector_valid),
        .halt_wake            (halt_wake)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Flags/enables as integers; m_phase: 0 nothing outstanding,
    // 1 CPU being asked, 2 vector being presented.
    int m_if, m_ie, m_phase, m_vec;
    bit m_ime, m_arm, m_req, m_valid, m_wake;

    always @(posedge cpu_clock or posedge reset) begin
        int src, pend_now, if_in, ie_in, eff, idx, nxt, new_if;
        bit ok, accept, ime, arm;
        if (reset) begin
            m_if = 0; m_ie = 0; m_phase = 0; m_vec = 0;
            m_ime = 0; m_arm = 0; m_req = 0; m_valid = 0; m_wake = 0;
        end else begin
            src = vblank_int + 2 * lcdc_int + 4 * timer_int
                + 8 * link_cable_interrupt + 16 * joypad_int;
            pend_now = m_if & m_ie & 31;
            if_in = (mem_we && addr_in_IF) ? (int'(data_ext) & 31) : m_if;
            ie_in = (mem_we && addr_in_IE) ? int'(data_ext) : m_ie;
            eff = if_in & ie_in & 31;
            idx = -1;
            for (int b = 4; b >= 0; b--) if (((eff >> b) & 1) == 1) idx = b;
            ok = m_ime && (pend_now != 0);
            accept = (m_phase == 1) && ok && int_ack;
            if (m_phase == 0)      nxt = ok ? 1 : 0;
            else if (m_phase == 1) nxt = !ok ? 0 : (int_ack ? 2 : 1);
            else                   nxt = 0;
            new_if = if_in | src;
            if (accept && idx >= 0 && ((src >> idx) & 1) == 0) new_if = new_if & ~(1 << idx);
            ime = m_ime; arm = m_arm;
            if (di) begin
                ime = 0; arm = 0;
            end else begin
                if (reti) ime = 1;
                if (m_arm && instr_done) begin ime = 1; arm = 0; end
                if (ei) arm = 1;
            end
            if (accept) begin
                ime = 0;
                m_vec = (idx >= 0) ? (64 + 8 * idx) : 0;
            end
            m_wake  = (pend_now != 0);
            m_req   = (nxt == 1);
            m_valid = (nxt == 2);
            m_if = new_if; m_ie = ie_in; m_ime = ime; m_arm = arm; m_phase = nxt;
        end
    end

    // Every-cycle comparison of the registered outputs against the model
    always @(negedge cpu_clock) begin
        if (!reset) begin
            check("model_int_req",   {15'd0, int_req},          {15'd0, m_req});
            check("model_valid",     {15'd0, int_vector_valid}, {15'd0, m_valid});
            check("model_vector",    int_vector,                m_vec[15:0]);
            check("model_halt_wake", {15'd0, halt_wake},        {15'd0, m_wake});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge cpu_clock);
    endtask

    task automatic clear_inputs();
        drv = 8'h00; drv_en = 0;
        addr_in_IF = 0; addr_in_IE = 0; mem_we = 0; mem_re = 0;
        vblank_int = 0; lcdc_int = 0; timer_int = 0; link_cable_interrupt = 0; joypad_int = 0;
        ei = 0; di = 0; reti = 0; instr_done = 0; int_ack = 0;
    endtask

    // Hold whatever inputs are set across one rising edge, then release them
    task automatic pulse_cycle();
        step();
        clear_inputs();
    endtask

    task automatic write_reg(input bit to_if, input logic [7:0] val);
        addr_in_IF = to_if; addr_in_IE = !to_if; mem_we = 1; drv = val; drv_en = 1;
        pulse_cycle();
    endtask

    task automatic read_check(input string name, input bit from_if, input logic [7:0] exp);
        addr_in_IF = from_if; addr_in_IE = !from_if; mem_re = 1;
        #1;
        check(name, {8'h00, data_ext}, {8'h00, exp});
        mem_re = 0; addr_in_IF = 0; addr_in_IE = 0;
    endtask

    task automatic wait_req(input string name, input int max_cycles);
        int k;
        k = 0;
        while (int_req !== 1'b1 && k < max_cycles) begin
            step();
            k++;
        end
        check(name, {15'd0, int_req}, 16'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        reset = 0;
        #1 reset = 1;
        repeat (3) step();
        reset = 0;

        // Reset state
        check("rst_int_req",   {15'd0, int_req},          16'd0);
        check("rst_vector",    int_vector,                16'h0000);
        check("rst_valid",     {15'd0, int_vector_valid}, 16'd0);
        check("rst_halt_wake", {15'd0, halt_wake},        16'd0);
        read_check("rst_if_read", 1, 8'hE0);
        read_check("rst_ie_read", 0, 8'h00);

        // Single timer interrupt end to end
        write_reg(0, 8'h1F);
        reti = 1; pulse_cycle();
        timer_int = 1; pulse_cycle();
        check("t_wake_lat", {15'd0, halt_wake}, 16'd0);
        read_check("t_if_flag", 1, 8'hE4);
        step();
        check("t_wake", {15'd0, halt_wake}, 16'd1);
        check("t_req",  {15'd0, int_req},   16'd1);
        int_ack = 1; pulse_cycle();
        check("t_valid",  {15'd0, int_vector_valid}, 16'd1);
        check("t_vector", int_vector,                16'h0050);
        check("t_req_dn", {15'd0, int_req},          16'd0);
        read_check("t_if_clr", 1, 8'hE0);
        step();
        check("t_valid_1cyc", {15'd0, int_vector_valid}, 16'd0);
        check("t_vec_hold",   int_vector,                16'h0050);
        timer_int = 1; pulse_cycle();
        step(); step();
        check("t_ime_off_req",  {15'd0, int_req},   16'd0);
        check("t_ime_off_wake", {15'd0, halt_wake}, 16'd1);
        write_reg(1, 8'h00);

        // Two simultaneous sources: priority and second dispatch after reti
        reti = 1; pulse_cycle();
        vblank_int = 1; link_cable_interrupt = 1; pulse_cycle();
        wait_req("p_req1", 4);
        int_ack = 1; pulse_cycle();
        check("p_vec1", int_vector, 16'h0040);
        read_check("p_if_after1", 1, 8'hE8);
        reti = 1; pulse_cycle();
        wait_req("p_req2", 4);
        int_ack = 1; pulse_cycle();
        check("p_vec2", int_vector, 16'h0058);
        read_check("p_if_after2", 1, 8'hE0);
        step();

        // ei takes effect only after the next instruction boundary
        lcdc_int = 1; pulse_cycle();
        ei = 1; pulse_cycle();
        step(); check("e_req_wait1", {15'd0, int_req}, 16'd0);
        step(); check("e_req_wait2", {15'd0, int_req}, 16'd0);
        instr_done = 1; pulse_cycle();
        check("e_req_at_done", {15'd0, int_req}, 16'd0);
        step();
        check("e_req_after", {15'd0, int_req}, 16'd1);
        int_ack = 1; pulse_cycle();
        check("e_vec", int_vector, 16'h0048);
        step();
        lcdc_int = 1; pulse_cycle();
        ei = 1; di = 1; pulse_cycle();
        instr_done = 1; pulse_cycle();
        for (int i = 0; i < 3; i++) begin
            step();
            check("e_di_wins", {15'd0, int_req}, 16'd0);
        end
        write_reg(1, 8'h00);

        // Request withdrawn by di before ack; a late ack in IDLE is ignored
        reti = 1; pulse_cycle();
        timer_int = 1; pulse_cycle();
        wait_req("c_req", 4);
        di = 1; pulse_cycle();
        step();
        check("c_req_drop", {15'd0, int_req}, 16'd0);
        int_ack = 1; pulse_cycle();
        check("c_idle_ack_valid", {15'd0, int_vector_valid}, 16'd0);
        check("c_idle_ack_vec",   int_vector,                16'h0048);
        write_reg(1, 8'h00);

        // IF cleared by the CPU in the same cycle as the ack
        reti = 1; pulse_cycle();
        link_cable_interrupt = 1; pulse_cycle();
        wait_req("x_req", 4);
        addr_in_IF = 1; mem_we = 1; drv = 8'h00; drv_en = 1; int_ack = 1;
        pulse_cycle();
        check("x_valid",  {15'd0, int_vector_valid}, 16'd1);
        check("x_vector", int_vector,                16'h0000);
        step();
        timer_int = 1; pulse_cycle();
        step(); step();
        check("x_ime_off", {15'd0, int_req}, 16'd0);
        write_reg(1, 8'h00);

        // Source pulse wins over a simultaneous IF=0 write
        joypad_int = 1; addr_in_IF = 1; mem_we = 1; drv = 8'h00; drv_en = 1;
        pulse_cycle();
        read_check("j_if_read", 1, 8'hF0);
        write_reg(1, 8'h00);
        step();

        // Asynchronous reset in the middle of a dispatch
        reti = 1; pulse_cycle();
        vblank_int = 1; pulse_cycle();
        wait_req("r_req", 4);
        int_ack = 1; pulse_cycle();
        check("r_in_dispatch", {15'd0, int_vector_valid}, 16'd1);
        reset = 1;
        #1;
        check("r_int_req",   {15'd0, int_req},          16'd0);
        check("r_vector",    int_vector,                16'h0000);
        check("r_valid",     {15'd0, int_vector_valid}, 16'd0);
        check("r_halt_wake", {15'd0, halt_wake},        16'd0);
        read_check("r_if_read", 1, 8'hE0);
        read_check("r_ie_read", 0, 8'h00);
        step();
        reset = 0;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
